fv_bank_requester: RTL and testbench

FV_BANK_REQUESTER -- requirements
Module: fv_bank_requester

---
 rtl/fv_bank_requester.sv | 127 ++++++++++++
 tb/tb_fv_bank_requester.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fv_bank_requester.sv
// fv_bank_requester: per-PE feature-value reader / write-back requester for one SRAM bank.
// Defining FV_REQ_TIMEOUT_EN adds a watchdog of FV_REQ_TIMEOUT_CYCLES idle cycles (default 32).
`ifndef Max_Node_id
`define Max_Node_id 64
`endif
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef Max_FV_num
`define Max_FV_num 16
`endif
`ifndef FV_bandwidth
`define FV_bandwidth 64
`endif
package fv_bank_pkg;
  localparam int NW = $clog2(`Max_Node_id);
  localparam int TW = $clog2(`Num_Edge_PE);
  localparam int FW = $clog2(`Max_FV_num) + 1;
  localparam int AW = $clog2(`Max_FV_num / 2);
  localparam int BW = `FV_bandwidth;
  localparam int LINES = `Max_FV_num / 2;
  typedef struct packed {
    logic valid;
    logic rd_wr;
    logic wr_eos;
    logic [NW-1:0] Node_id;
    logic [TW-1:0] PE_tag;
    logic [BW-1:0] data;
  } Req2Output_SRAM_Bank;
  typedef struct packed {
    logic valid;
    logic sos;
    logic eos;
    logic [TW-1:0] PE_tag;
    logic [BW-1:0] FV_data;
  } FV_bank_CNTL2Edge_PE;
endpackage

module fv_bank_requester
  import fv_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rd_start,
  input  logic wr_start,
  input  logic [NW-1:0] node_id,
  input  logic [TW-1:0] pe_tag,
  input  logic [FW-1:0] fv_num,
  input  logic [BW-1:0] wr_data,
  input  logic wr_data_valid,
  output logic wr_data_ready,
  input  logic bank_available,
  output Req2Output_SRAM_Bank req_pkt,
  input  FV_bank_CNTL2Edge_PE rd_in,
  input  logic [AW-1:0] buf_addr,
  output logic [BW-1:0] buf_data,
  output logic busy,
  output logic done,
  output logic err
);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_COLLECT = 3'd2, WR_REQ = 3'd3, WR_STREAM = 3'd4;
  logic [2:0] state, state_nx;
  logic [NW-1:0] node;
  logic [FW-1:0] lines, lines_in, cnt, idx, beats;
  logic [FW:0] fv_up;
  logic acc, full, we, wr_beat, last, timeout;
  logic [BW-1:0] buffer [LINES];
  assign fv_up = {1'b0, fv_num} + 1'b1;
  assign lines_in = fv_num == '0 ? FW'(1) : fv_up[FW:1];
  assign acc = state == RD_COLLECT && rd_in.valid && rd_in.PE_tag == pe_tag;
  // sos restarts the line index in the same beat it is written
  assign idx = rd_in.sos ? '0 : cnt;
  assign full = idx >= FW'(LINES);
  assign we = acc && !full;
  assign beats = full ? cnt : idx + 1'b1;
  assign wr_beat = wr_data_valid && (state == WR_REQ && bank_available || state == WR_STREAM);
  assign last = cnt + 1'b1 == lines;
  assign done = acc && rd_in.eos || wr_beat && last || timeout;
  assign wr_data_ready = wr_beat;
  assign busy = state != IDLE;
  assign buf_data = buffer[buf_addr];
  assign req_pkt = wr_beat ? Req2Output_SRAM_Bank'{1'b1, 1'b1, last, node, pe_tag, wr_data} :
                   state == RD_REQ && bank_available ? Req2Output_SRAM_Bank'{1'b1, 1'b0, 1'b0, node, pe_tag, BW'(0)} :
                   '0;
  always_comb begin
    state_nx = done ? IDLE :
               state == IDLE ? (rd_start ? RD_REQ : wr_start ? WR_REQ : IDLE) :
               state == RD_REQ ? (bank_available ? RD_COLLECT : RD_REQ) :
               state == WR_REQ ? (wr_beat ? WR_STREAM : WR_REQ) :
               state > WR_STREAM ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      node <= '0;
      lines <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (rd_start || wr_start)) begin
        node <= node_id;
        lines <= lines_in;
        cnt <= '0;
      end
      if (we) cnt <= idx + 1'b1;
      if (wr_beat) cnt <= cnt + 1'b1;
      if (acc && (full || rd_in.eos && beats != lines) || timeout) err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (we) buffer[idx[AW-1:0]] <= rd_in.FV_data;
`ifdef FV_REQ_TIMEOUT_EN
`ifndef FV_REQ_TIMEOUT_CYCLES
`define FV_REQ_TIMEOUT_CYCLES 32
`endif
  localparam int WW = $clog2(`FV_REQ_TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wd;
  logic waiting;
  assign waiting = (state == RD_COLLECT || state == WR_STREAM) && !acc && !wr_beat;
  assign timeout = waiting && wd == WW'(`FV_REQ_TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) wd <= '0;
    else wd <= waiting && !timeout ? wd + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_fv_bank_requester.sv
// tb_fv_bank_requester: scoreboard bench for fv_bank_requester in its default build.
module tb_fv_bank_requester;
  import fv_bank_pkg::*;
  logic clk = 1'b0, reset = 1'b1, rd_start = 1'b0, wr_start = 1'b0;
  logic wr_data_valid = 1'b0, bank_available = 1'b1;
  logic [NW-1:0] node_id = '0;
  logic [TW-1:0] pe_tag = TW'(2);
  logic [FW-1:0] fv_num = '0;
  logic [BW-1:0] wr_data = '0, buf_data;
  logic [AW-1:0] buf_addr = '0;
  logic wr_data_ready, busy, done, err;
  Req2Output_SRAM_Bank req_pkt, mon_exp;
  FV_bank_CNTL2Edge_PE rd_in = '0;
  Req2Output_SRAM_Bank exp_q[$];
  logic [BW-1:0] buf_q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fv_bank_requester dut (
    .clk(clk), .reset(reset), .rd_start(rd_start), .wr_start(wr_start),
    .node_id(node_id), .pe_tag(pe_tag), .fv_num(fv_num), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .bank_available(bank_available), .req_pkt(req_pkt), .rd_in(rd_in),
    .buf_addr(buf_addr), .buf_data(buf_data), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk)
    if (!reset) begin
      n_cmp++;
      if (!req_pkt.valid) begin
        if (req_pkt !== '0) begin n_bad++; $display("FAIL idle_pkt: got %h want 0", req_pkt); end
      end else if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL pkt_extra: got %h want none", req_pkt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (req_pkt !== mon_exp) begin n_bad++; $display("FAIL pkt: got %h want %h", req_pkt, mon_exp); end
      end
    end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic Req2Output_SRAM_Bank mk(bit rw, bit eos, logic [NW-1:0] n, logic [BW-1:0] d);
    mk = '0;
    mk.valid = 1'b1; mk.rd_wr = rw; mk.wr_eos = eos; mk.Node_id = n; mk.PE_tag = pe_tag; mk.data = d;
  endfunction

  task automatic beat(bit v, bit s, bit e, logic [TW-1:0] t, logic [BW-1:0] d);
    cyc();
    rd_in.valid = v; rd_in.sos = s; rd_in.eos = e; rd_in.PE_tag = t; rd_in.FV_data = d;
  endtask

  task automatic start_rd(logic [NW-1:0] n, logic [FW-1:0] f, bit both);
    cyc();
    rd_start = 1'b1; wr_start = both; node_id = n; fv_num = f;
    exp_q.push_back(mk(1'b0, 1'b0, n, '0));
    cyc();
    rd_start = 1'b0; wr_start = 1'b0; node_id = '0; fv_num = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #2;
    n_cmp++; if ({busy, done, err, wr_data_ready} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, wr_data_ready}); end
    n_cmp++; if (req_pkt !== '0) begin n_bad++; $display("FAIL reset_pkt: got %h want 0", req_pkt); end
    cyc(); cyc(); reset = 1'b0;
  endtask

  task automatic test_read();
    logic [BW-1:0] d;
    start_rd(NW'(12), FW'(16), 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom}; buf_q.push_back(d);
      beat(1'b1, i == 0, i == 7, TW'(2), d);
      @(negedge clk);
      n_cmp++; if (done !== (i == 7)) begin n_bad++; $display("FAIL read_done[%0d]: got %b want %b", i, done, i == 7); end
    end
    cyc(); rd_in = '0;
    n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL read_end: busy,err got %b want 00", {busy, err}); end
    for (int i = 0; i < 8; i++) begin
      buf_addr = AW'(i); #1; d = buf_q.pop_front();
      n_cmp++; if (buf_data !== d) begin n_bad++; $display("FAIL read_buf[%0d]: got %h want %h", i, buf_data, d); end
    end
  endtask

  task automatic test_foreign();
    logic [BW-1:0] d;
    start_rd(NW'(33), FW'(8), 1'b0);
    for (int i = 0; i < 7; i++) begin
      d = {$urandom, $urandom};
      if (i % 2 == 0) begin buf_q.push_back(d); beat(1'b1, i == 0, i == 6, TW'(2), d); end
      else beat(1'b1, i == 5, i == 3, TW'(3), d);
      @(negedge clk);
      n_cmp++; if (done !== (i == 6)) begin n_bad++; $display("FAIL foreign_done[%0d]: got %b want %b", i, done, i == 6); end
    end
    cyc(); rd_in = '0;
    n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL foreign_end: busy,err got %b want 00", {busy, err}); end
    for (int i = 0; i < 4; i++) begin
      buf_addr = AW'(i); #1; d = buf_q.pop_front();
      n_cmp++; if (buf_data !== d) begin n_bad++; $display("FAIL foreign_buf[%0d]: got %h want %h", i, buf_data, d); end
    end
  endtask

  task automatic test_write();
    logic [BW-1:0] d0, d1, d2;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    cyc(); wr_start = 1'b1; node_id = NW'(5); fv_num = FW'(6);
    cyc(); wr_start = 1'b0; node_id = '0; fv_num = '0; bank_available = 1'b0; wr_data_valid = 1'b1; wr_data = d0;
    @(negedge clk);
    n_cmp++; if (wr_data_ready !== 1'b0) begin n_bad++; $display("FAIL wr_bank_wait: ready got %b want 0", wr_data_ready); end
    cyc(); bank_available = 1'b1; exp_q.push_back(mk(1'b1, 1'b0, NW'(5), d0));
    @(negedge clk);
    n_cmp++; if ({wr_data_ready, done} !== 2'b10) begin n_bad++; $display("FAIL wr_beat0: ready,done got %b want 10", {wr_data_ready, done}); end
    cyc(); wr_data = d1; exp_q.push_back(mk(1'b1, 1'b0, NW'(5), d1));
    @(negedge clk);
    n_cmp++; if (wr_data_ready !== 1'b1) begin n_bad++; $display("FAIL wr_beat1: ready got %b want 1", wr_data_ready); end
    cyc(); wr_data_valid = 1'b0; wr_data = {$urandom, $urandom};
    @(negedge clk);
    n_cmp++; if ({req_pkt.valid, wr_data_ready} !== 2'b00) begin n_bad++; $display("FAIL wr_gap: valid,ready got %b want 00", {req_pkt.valid, wr_data_ready}); end
    cyc(); wr_data_valid = 1'b1; wr_data = d2; exp_q.push_back(mk(1'b1, 1'b1, NW'(5), d2));
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %b want 1", done); end
    cyc(); wr_data_valid = 1'b0;
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL wr_end: busy,done,err got %b want 000", {busy, done, err}); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wr_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_single_write();
    logic [BW-1:0] d;
    d = {$urandom, $urandom};
    cyc(); wr_start = 1'b1; node_id = NW'(7); fv_num = FW'(0);
    cyc(); wr_start = 1'b0; wr_data_valid = 1'b1; wr_data = d; exp_q.push_back(mk(1'b1, 1'b1, NW'(7), d));
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
    cyc(); wr_data_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    start_rd(NW'(3), FW'(16), 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, i == 0, i == 4, TW'(2), {$urandom, $urandom});
      @(negedge clk);
      n_cmp++; if (done !== (i == 4)) begin n_bad++; $display("FAIL mism_done[%0d]: got %b want %b", i, done, i == 4); end
    end
    cyc(); rd_in = '0;
    n_cmp++; if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL mism_err: busy,err got %b want 01", {busy, err}); end
  endtask

  task automatic test_reset_midread();
    logic [BW-1:0] d;
    start_rd(NW'(9), FW'(16), 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b1, i == 0, 1'b0, TW'(2), {$urandom, $urandom});
    reset = 1'b1; #1;
    n_cmp++; if ({busy, done, err, wr_data_ready} !== 4'b0) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 0000", {busy, done, err, wr_data_ready}); end
    n_cmp++; if (req_pkt !== '0) begin n_bad++; $display("FAIL rst_mid_pkt: got %h want 0", req_pkt); end
    rd_in = '0;
    cyc(); cyc(); reset = 1'b0;
    start_rd(NW'(10), FW'(4), 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom}; buf_q.push_back(d);
      beat(1'b1, i == 0, i == 1, TW'(2), d);
      @(negedge clk);
      n_cmp++; if (done !== (i == 1)) begin n_bad++; $display("FAIL rst_rd_done[%0d]: got %b want %b", i, done, i == 1); end
    end
    cyc(); rd_in = '0;
    n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL rst_rd_end: busy,err got %b want 00", {busy, err}); end
    for (int i = 0; i < 2; i++) begin
      buf_addr = AW'(i); #1; d = buf_q.pop_front();
      n_cmp++; if (buf_data !== d) begin n_bad++; $display("FAIL rst_rd_buf[%0d]: got %h want %h", i, buf_data, d); end
    end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] d;
    start_rd(NW'(20), FW'(16), 1'b0);
    for (int i = 0; i < 9; i++) begin
      d = {$urandom, $urandom};
      if (i < 8) buf_q.push_back(d);
      beat(1'b1, i == 0, i == 8, TW'(2), d);
      @(negedge clk);
      n_cmp++; if (done !== (i == 8)) begin n_bad++; $display("FAIL ovf_done[%0d]: got %b want %b", i, done, i == 8); end
    end
    cyc(); rd_in = '0;
    n_cmp++; if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL ovf_err: busy,err got %b want 01", {busy, err}); end
    for (int i = 0; i < 8; i++) begin
      buf_addr = AW'(i); #1; d = buf_q.pop_front();
      n_cmp++; if (buf_data !== d) begin n_bad++; $display("FAIL ovf_buf[%0d]: got %h want %h", i, buf_data, d); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_foreign();
    test_write();
    test_single_write();
    test_mismatch();
    test_reset_midread();
    test_overflow();
    cyc(); cyc();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL pkt_pending: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
